// File: rtl/ir_sensor_drive_sequencer_if.sv
// Signal bundle between the IR sensor drive sequencer (master) and its pad/decay-counter consumers (slave).
interface ir_sensor_drive_sequencer_if;
  logic        enable;
  logic        sensor_out;
  logic        sensor_oe;
  logic        emitter_on;
  logic        meas_start;
  logic        meas_window;
  logic        cycle_done;
  logic        busy;
  logic [15:0] cycle_count;

  modport master (
    input  enable,
    output sensor_out, sensor_oe, emitter_on, meas_start, meas_window,
    output cycle_done, busy, cycle_count
  );

  modport slave (
    output enable,
    input  sensor_out, sensor_oe, emitter_on, meas_start, meas_window,
    input  cycle_done, busy, cycle_count
  );
endinterface

// File: rtl/ir_sensor_drive_sequencer.sv
// Charge / measure / holdoff sequencer for one RC IR reflectance sensor line; all outputs registered.
// Optional macro IR_EMITTER_GATE_EN: emitter_on only during CHARGE and MEASURE, otherwise always on out of reset.
module ir_sensor_drive_sequencer #(
  parameter int CHARGE_CYCLES = 500,
  parameter int TIMEOUT       = 2000,
  parameter int PERIOD        = 50000
) (
  input  logic                               clock,
  input  logic                               reset,
  ir_sensor_drive_sequencer_if.master        sdif
);

  // Holdoff is whatever remains of the period, but never less than one clock.
  localparam int HOLD_RAW = PERIOD - CHARGE_CYCLES - TIMEOUT;
  localparam int HOLD     = (HOLD_RAW >= 1) ? HOLD_RAW : 1;
  localparam int MAX_CT   = (CHARGE_CYCLES > TIMEOUT) ? CHARGE_CYCLES : TIMEOUT;
  localparam int MAX_ALL  = (MAX_CT > PERIOD) ? MAX_CT : PERIOD;
  localparam int CW       = ($clog2(MAX_ALL) < 1) ? 1 : $clog2(MAX_ALL);

  localparam logic [CW-1:0] CHARGE_LAST  = CW'(CHARGE_CYCLES - 1);
  localparam logic [CW-1:0] MEASURE_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHARGE  = 2'd1,
    S_MEASURE = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   cycle_count_q, cycle_count_d;
  logic          sensor_oe_q, sensor_oe_d;
  logic          sensor_out_q, sensor_out_d;
  logic          emitter_on_q, emitter_on_d;
  logic          meas_start_q, meas_start_d;
  logic          meas_window_q, meas_window_d;
  logic          cycle_done_q, cycle_done_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cycle_count_d = cycle_count_q;

    case (state_q)
      S_IDLE: begin
        if (sdif.enable) begin
          state_d = S_CHARGE;
          cnt_d   = '0;
        end
      end
      S_CHARGE: begin
        if (cnt_q == CHARGE_LAST) begin
          state_d = S_MEASURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MEASURE: begin
        if (cnt_q == MEASURE_LAST) begin
          state_d       = S_HOLDOFF;
          cnt_d         = '0;
          cycle_count_d = cycle_count_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLDOFF: begin
        // enable is only looked at here, so a mid-cycle drop never truncates a window.
        if (cnt_q == HOLD_LAST) begin
          state_d = sdif.enable ? S_CHARGE : S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are the registered image of the next state, so they line up with state_q.
    sensor_oe_d   = (state_d == S_CHARGE);
    sensor_out_d  = (state_d == S_CHARGE);
    meas_window_d = (state_d == S_MEASURE);
    meas_start_d  = (state_d == S_MEASURE) && (state_q != S_MEASURE);
    cycle_done_d  = (state_d == S_HOLDOFF) && (state_q != S_HOLDOFF);
    busy_d        = (state_d != S_IDLE);
`ifdef IR_EMITTER_GATE_EN
    emitter_on_d  = (state_d == S_CHARGE) || (state_d == S_MEASURE);
`else
    emitter_on_d  = 1'b1;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cycle_count_q <= '0;
      sensor_oe_q   <= 1'b0;
      sensor_out_q  <= 1'b0;
      emitter_on_q  <= 1'b0;
      meas_start_q  <= 1'b0;
      meas_window_q <= 1'b0;
      cycle_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cycle_count_q <= cycle_count_d;
      sensor_oe_q   <= sensor_oe_d;
      sensor_out_q  <= sensor_out_d;
      emitter_on_q  <= emitter_on_d;
      meas_start_q  <= meas_start_d;
      meas_window_q <= meas_window_d;
      cycle_done_q  <= cycle_done_d;
      busy_q        <= busy_d;
    end
  end

  assign sdif.sensor_oe   = sensor_oe_q;
  assign sdif.sensor_out  = sensor_out_q;
  assign sdif.emitter_on  = emitter_on_q;
  assign sdif.meas_start  = meas_start_q;
  assign sdif.meas_window = meas_window_q;
  assign sdif.cycle_done  = cycle_done_q;
  assign sdif.busy        = busy_q;
  assign sdif.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_ir_sensor_drive_sequencer.sv
// Table-driven bench for the IR sensor drive sequencer (CHARGE=4, TIMEOUT=8, PERIOD=20) plus a clamped-holdoff instance.
module tb_ir_sensor_drive_sequencer;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ir_sensor_drive_sequencer_if ifa ();
  ir_sensor_drive_sequencer_if ifb ();

  ir_sensor_drive_sequencer #(.CHARGE_CYCLES(4), .TIMEOUT(8), .PERIOD(20)) dut_a (
    .clock (clock),
    .reset (reset),
    .sdif  (ifa.master)
  );

  ir_sensor_drive_sequencer #(.CHARGE_CYCLES(4), .TIMEOUT(8), .PERIOD(12)) dut_b (
    .clock (clock),
    .reset (reset),
    .sdif  (ifb.master)
  );

`ifdef IR_EMITTER_GATE_EN
  localparam logic GATED = 1'b1;
`else
  localparam logic GATED = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        en;
    logic        oe;
    logic        ms;
    logic        mw;
    logic        cd;
    logic        busy;
    logic [15:0] cnt;
    logic        em;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // em_g / em_u: expected emitter_on with and without emitter gating.
  task automatic addn(input int n, input logic rst, input logic en, input logic oe, input logic ms,
                      input logic mw, input logic cd, input logic busy, input logic [15:0] cnt,
                      input logic em_g, input logic em_u);
    vec_t v;
    v.rst = rst; v.en = en; v.oe = oe; v.ms = ms; v.mw = mw; v.cd = cd;
    v.busy = busy; v.cnt = cnt; v.em = GATED ? em_g : em_u;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    // Scenario A: basic cycle, enable held high; reset applied on clock 22.
    addn(1, 0,1, 0,0,0,0,0, 16'd0, 0,0);  // clk 0: reset state
    addn(4, 0,1, 1,0,0,0,1, 16'd0, 1,1);  // clk 1-4: CHARGE
    addn(1, 0,1, 0,1,1,0,1, 16'd0, 1,1);  // clk 5: meas_start
    addn(7, 0,1, 0,0,1,0,1, 16'd0, 1,1);  // clk 6-12
    addn(1, 0,1, 0,0,0,1,1, 16'd1, 0,1);  // clk 13: cycle_done
    addn(7, 0,1, 0,0,0,0,1, 16'd1, 0,1);  // clk 14-20
    addn(1, 0,1, 1,0,0,0,1, 16'd1, 1,1);  // clk 21: next CHARGE
    addn(1, 1,1, 1,0,0,0,1, 16'd1, 1,1);  // clk 22: reset sampled at end
    // Scenario B: enable drops on clock 2, cycle still completes, then IDLE.
    addn(1, 0,1, 0,0,0,0,0, 16'd0, 0,0);
    addn(1, 0,1, 1,0,0,0,1, 16'd0, 1,1);
    addn(3, 0,0, 1,0,0,0,1, 16'd0, 1,1);
    addn(1, 0,0, 0,1,1,0,1, 16'd0, 1,1);
    addn(7, 0,0, 0,0,1,0,1, 16'd0, 1,1);
    addn(1, 0,0, 0,0,0,1,1, 16'd1, 0,1);
    addn(7, 0,0, 0,0,0,0,1, 16'd1, 0,1);
    addn(2, 0,0, 0,0,0,0,0, 16'd1, 0,1);  // clk 21-22: IDLE, count holds
    // Scenario C: restart from IDLE, reset mid-MEASURE on clock 8, then restart.
    addn(1, 0,1, 0,0,0,0,0, 16'd1, 0,1);
    addn(4, 0,1, 1,0,0,0,1, 16'd1, 1,1);
    addn(1, 0,1, 0,1,1,0,1, 16'd1, 1,1);
    addn(2, 0,1, 0,0,1,0,1, 16'd1, 1,1);
    addn(1, 1,1, 0,0,1,0,1, 16'd1, 1,1);  // clk 8: reset asserted
    addn(1, 0,1, 0,0,0,0,0, 16'd0, 0,0);  // clk 9: everything cleared
    addn(2, 0,0, 1,0,0,0,1, 16'd0, 1,1);  // clk 10-11: CHARGE again

    reset = 1'b1;
    ifa.enable = 1'b0;
    ifb.enable = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      reset      = tbl[i].rst;
      ifa.enable = tbl[i].en;
      @(negedge clock);
      chk("sensor_oe",   i, 16'(ifa.sensor_oe),   16'(tbl[i].oe));
      chk("sensor_out",  i, 16'(ifa.sensor_out),  16'(tbl[i].oe));
      chk("meas_start",  i, 16'(ifa.meas_start),  16'(tbl[i].ms));
      chk("meas_window", i, 16'(ifa.meas_window), 16'(tbl[i].mw));
      chk("cycle_done",  i, 16'(ifa.cycle_done),  16'(tbl[i].cd));
      chk("busy",        i, 16'(ifa.busy),        16'(tbl[i].busy));
      chk("cycle_count", i, ifa.cycle_count,      tbl[i].cnt);
      chk("emitter_on",  i, 16'(ifa.emitter_on),  16'(tbl[i].em));
      @(posedge clock);
      #1;
    end

    // Clamped holdoff: PERIOD=12 gives a one-clock HOLDOFF and a 13-clock period.
    reset = 1'b1;
    ifa.enable = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    ifb.enable = 1'b1;
    for (int c = 0; c < 28; c++) begin
      logic exp_oe, exp_cd, exp_mw;
      exp_oe = (c >= 1 && c <= 4) || (c >= 14 && c <= 17) || (c == 27);
      exp_mw = (c >= 5 && c <= 12) || (c >= 18 && c <= 25);
      exp_cd = (c == 13) || (c == 26);
      @(negedge clock);
      chk("clamp_oe",   c, 16'(ifb.sensor_oe),   16'(exp_oe));
      chk("clamp_mw",   c, 16'(ifb.meas_window), 16'(exp_mw));
      chk("clamp_done", c, 16'(ifb.cycle_done),  16'(exp_cd));
      chk("clamp_busy", c, 16'(ifb.busy),        16'(c != 0));
      if (c == 13) chk("clamp_count1", c, ifb.cycle_count, 16'd1);
      if (c == 26) chk("clamp_count2", c, ifb.cycle_count, 16'd2);
      @(posedge clock);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
